sseg_scan_display: RTL and testbench

SSEG_SCAN_DISPLAY -- requirements
Module: sseg_scan_display

---
 rtl/sseg_scan_display.sv | 179 +++++++++++++++++
 tb/tb_sseg_scan_display.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_display.sv
// sseg_scan_display: captures a binary value, converts it to BCD with a
// shift-and-add-3 FSM and shows it on a multiplexed seven-segment display.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset
//   ack      - db valid, sampled only on an input tick while idle
//   db       - unsigned binary value to display (DATA_W bits)
//   blank_lz - 1 = blank leading zero digits
//   sseg     - registered active-low segments, bit7 = DP, bits6..0 = g..a
//   en       - registered one-hot-low digit enable (DIGITS bits)
//   busy     - high while a conversion is in progress
`timescale 1ns/1ps
module sseg_scan_display #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned IN_DIV   = 25500,
  parameter int unsigned SCAN_DIV = 60000,
  parameter int unsigned DP_POS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack,
  input  logic [DATA_W-1:0] db,
  input  logic              blank_lz,
  output logic [7:0]        sseg,
  output logic [DIGITS-1:0] en,
  output logic              busy
);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned     BCD_W   = 4 * DIGITS;
  localparam int unsigned     IN_CW   = (IN_DIV < 1) ? 1 : $clog2(IN_DIV + 1);
  localparam int unsigned     SC_CW   = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam int unsigned     SH_CW   = $clog2(DATA_W + 1);
  localparam int unsigned     IDX_W   = $clog2(DIGITS);
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IN_CW-1:0]   in_cnt;
  logic [SC_CW-1:0]   sc_cnt;
  logic               in_tick, sc_tick;
  logic [DATA_W-1:0]  bin_sr;
  logic [BCD_W-1:0]   bcd_sr, bcd_adj, buf_bcd;
  logic [SH_CW-1:0]   sh_cnt;
  logic               ovf_pend, ovf;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         seg_nxt;
  logic [DIGITS-1:0]  en_nxt;

  // Tick generators: free-running, wrap to 0 on the tick cycle.
  assign in_tick = (in_cnt == IN_CW'(IN_DIV));
  assign sc_tick = (sc_cnt == SC_CW'(SCAN_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt <= '0;
      sc_cnt <= '0;
    end else begin
      in_cnt <= in_tick ? '0 : in_cnt + IN_CW'(1);
      sc_cnt <= sc_tick ? '0 : sc_cnt + SC_CW'(1);
    end
  end

  // Converter FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_tick && ack) state_nxt = SHIFT;
      SHIFT:   if (sh_cnt == SH_CW'(DATA_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction on every nibble before each shift.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      else                          bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4];
    end
  end

  // Overflow is decided at capture time since the BCD register cannot hold
  // values beyond DIGITS decimal digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      sh_cnt   <= '0;
      ovf_pend <= 1'b0;
      buf_bcd  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_tick && ack) begin
          bin_sr   <= db;
          bcd_sr   <= '0;
          sh_cnt   <= '0;
          ovf_pend <= (64'(db) > MAX_VAL);
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          sh_cnt           <= sh_cnt + SH_CW'(1);
        end
        DONE: begin
          buf_bcd <= bcd_sr;
          ovf     <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // Digit pattern for the current scan index; registered only on a scan
  // tick so a buffer update can never tear a displayed digit.
  always_comb begin
    logic [3:0]  nib;
    logic        upper_zero;
    int unsigned idx_u;
    nib        = '0;
    upper_zero = 1'b1;
    idx_u      = 32'(idx);
    seg_nxt    = 8'hFF;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (d == idx_u) nib = buf_bcd[4*d +: 4];
      if (d >= idx_u && buf_bcd[4*d +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (ovf) begin
      seg_nxt = 8'hBF;
    end else if (blank_lz && upper_zero && idx_u > DP_POS && idx_u != 0) begin
      seg_nxt = 8'hFF;
    end else begin
      case (nib)
        4'd0:    seg_nxt = 8'hC0;
        4'd1:    seg_nxt = 8'hF9;
        4'd2:    seg_nxt = 8'hA4;
        4'd3:    seg_nxt = 8'hB0;
        4'd4:    seg_nxt = 8'h99;
        4'd5:    seg_nxt = 8'h92;
        4'd6:    seg_nxt = 8'h82;
        4'd7:    seg_nxt = 8'hF8;
        4'd8:    seg_nxt = 8'h80;
        4'd9:    seg_nxt = 8'h90;
        default: seg_nxt = 8'hFF;
      endcase
      if (idx_u == DP_POS) seg_nxt[7] = 1'b0;
    end
    en_nxt = ~(DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sseg <= 8'hFF;
      en   <= '1;
      idx  <= '0;
    end else if (sc_tick) begin
      sseg <= seg_nxt;
      en   <= en_nxt;
      idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_sseg_scan_display.sv
// tb_sseg_scan_display: directed bench for sseg_scan_display. Two instances:
// dut_a (6 digits) and dut_b (3 digits), both with short tick dividers.
`timescale 1ns/1ps
module tb_sseg_scan_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ack_a = 1'b0, blank_a = 1'b0, busy_a;
  logic [9:0] db_a = '0;
  logic [7:0] sseg_a;
  logic [5:0] en_a;
  logic       ack_b = 1'b0, blank_b = 1'b0, busy_b;
  logic [9:0] db_b = '0;
  logic [7:0] sseg_b;
  logic [2:0] en_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sseg_scan_display #(.DATA_W(10), .DIGITS(6), .IN_DIV(5), .SCAN_DIV(7), .DP_POS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ack(ack_a), .db(db_a), .blank_lz(blank_a),
    .sseg(sseg_a), .en(en_a), .busy(busy_a));

  sseg_scan_display #(.DATA_W(10), .DIGITS(3), .IN_DIV(5), .SCAN_DIV(5), .DP_POS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ack(ack_b), .db(db_b), .blank_lz(blank_b),
    .sseg(sseg_b), .en(en_b), .busy(busy_b));

  // Start a conversion and return how many sampled cycles busy stayed high
  // (0 if busy never rose within the bound).
  task automatic convert(input bit sel, input logic [9:0] value, output int unsigned bc);
    bit seen;
    bc = 0;
    seen = 1'b0;
    @(negedge clk);
    if (sel) begin db_b = value; ack_b = 1'b1; end
    else     begin db_a = value; ack_a = 1'b1; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sel ? busy_b : busy_a) seen = 1'b1;
    end
    ack_a = 1'b0;
    ack_b = 1'b0;
    while (seen && (sel ? busy_b : busy_a) && bc < 40) begin
      bc++;
      @(negedge clk);
    end
  endtask

  // Record the pattern of each digit as it is scanned in after this call.
  task automatic read_scan(input bit sel, output logic [63:0] segs);
    logic [7:0] seen, full, en_cur, en_prev;
    segs = '0;
    seen = '0;
    full = sel ? 8'h07 : 8'h3F;
    en_prev = sel ? {5'h1F, en_b} : {2'b11, en_a};
    for (int c = 0; c < 200 && seen != full; c++) begin
      @(negedge clk);
      en_cur = sel ? {5'h1F, en_b} : {2'b11, en_a};
      if (en_cur != en_prev) begin
        for (int d = 0; d < 8; d++)
          if (en_cur == ~(8'd1 << d)) begin
            segs[8*d +: 8] = sel ? sseg_b : sseg_a;
            seen[d] = 1'b1;
          end
        en_prev = en_cur;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (sseg_a !== 8'hFF) begin failures++; $display("FAIL reset_sseg_a got=%h exp=ff", sseg_a); end
    checks++; if (en_a !== 6'h3F) begin failures++; $display("FAIL reset_en_a got=%h exp=3f", en_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    checks++; if (en_b !== 3'h7) begin failures++; $display("FAIL reset_en_b got=%h exp=7", en_b); end
  endtask

  // Tick lands in the cycle after SCAN_DIV=7 edges; outputs show after edge 8.
  task automatic test_first_scan;
    int n = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 50 && en_a == 6'h3F; i++) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 8) begin failures++; $display("FAIL first_scan_latency got=%0d exp=8", n); end
    checks++; if (en_a !== 6'h3E) begin failures++; $display("FAIL first_scan_en got=%h exp=3e", en_a); end
    checks++; if (sseg_a !== 8'hC0) begin failures++; $display("FAIL first_scan_sseg got=%h exp=c0", sseg_a); end
  endtask

  task automatic test_convert_237;
    int unsigned bc;
    logic [63:0] segs;
    logic [63:0] exp = {8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'h30, 8'hF8};
    blank_a = 1'b1;
    convert(1'b0, 10'd237, bc);
    checks++; if (bc != 11) begin failures++; $display("FAIL conv237_busy got=%0d exp=11", bc); end
    read_scan(1'b0, segs);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp[8*d +: 8]) begin
        failures++; $display("FAIL conv237 digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp[8*d +: 8]);
      end
    end
  endtask

  task automatic test_convert_5;
    int unsigned bc;
    logic [63:0] segs;
    logic [63:0] exp = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h92};
    blank_a = 1'b0;
    convert(1'b0, 10'd5, bc);
    read_scan(1'b0, segs);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp[8*d +: 8]) begin
        failures++; $display("FAIL conv5 digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp[8*d +: 8]);
      end
    end
  endtask

  // Digit 1 carries the DP and is never blanked even when it is a leading zero.
  task automatic test_blank_boundary;
    int unsigned bc;
    logic [63:0] segs;
    logic [63:0] exp = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hF8};
    blank_a = 1'b1;
    convert(1'b0, 10'd7, bc);
    read_scan(1'b0, segs);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp[8*d +: 8]) begin
        failures++; $display("FAIL blank7 digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp[8*d +: 8]);
      end
    end
  endtask

  task automatic test_ack_low;
    bit saw_busy = 1'b0;
    logic [63:0] segs;
    logic [63:0] exp = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hF8};
    ack_a = 1'b0;
    db_a = 10'd999;
    repeat (30) begin
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
    end
    checks++; if (saw_busy) begin failures++; $display("FAIL ack_low_busy got=1 exp=0"); end
    read_scan(1'b0, segs);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp[8*d +: 8]) begin
        failures++; $display("FAIL ack_low digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp[8*d +: 8]);
      end
    end
  endtask

  // With IN_DIV=5 a tick arrives 6 cycles after capture, inside the busy window.
  task automatic test_busy_ignore;
    bit seen = 1'b0;
    logic [63:0] segs;
    logic [63:0] exp = {8'hC0, 8'hC0, 8'hC0, 8'h82, 8'h79, 8'h80};
    blank_a = 1'b0;
    @(negedge clk);
    db_a = 10'd618;
    ack_a = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy_a) seen = 1'b1;
    end
    db_a = 10'd42;
    repeat (7) @(negedge clk);
    ack_a = 1'b0;
    for (int i = 0; i < 40 && busy_a; i++) @(negedge clk);
    checks++; if (!seen || busy_a) begin failures++; $display("FAIL busy_ignore_busy got=%b/%b exp=1/0", seen, busy_a); end
    read_scan(1'b0, segs);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp[8*d +: 8]) begin
        failures++; $display("FAIL busy_ignore digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp[8*d +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    bit seen = 1'b0;
    logic [63:0] segs;
    logic [63:0] exp = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hC0};
    blank_a = 1'b0;
    @(negedge clk);
    db_a = 10'd900;
    ack_a = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy_a) seen = 1'b1;
    end
    ack_a = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (!seen || busy_a !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b/%b exp=1/0", seen, busy_a); end
    checks++; if (sseg_a !== 8'hFF) begin failures++; $display("FAIL rst_mid_sseg got=%h exp=ff", sseg_a); end
    checks++; if (en_a !== 6'h3F) begin failures++; $display("FAIL rst_mid_en got=%h exp=3f", en_a); end
    @(negedge clk);
    rst_n = 1'b1;
    read_scan(1'b0, segs);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp[8*d +: 8]) begin
        failures++; $display("FAIL rst_mid digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp[8*d +: 8]);
      end
    end
  endtask

  task automatic test_scan_walk;
    logic [5:0] prev;
    int cur = -1;
    int ticks = 0;
    int gap = 0;
    prev = en_a;
    for (int d = 0; d < 6; d++) if (en_a == ~(6'd1 << d)) cur = d;
    for (int c = 0; c < 200 && ticks < 12; c++) begin
      @(negedge clk);
      gap++;
      if (en_a != prev) begin
        cur = (cur + 1) % 6;
        checks++;
        if (en_a !== ~(6'd1 << cur) || (ticks > 0 && gap != 8)) begin
          failures++; $display("FAIL scan_walk tick%0d got=%h gap=%0d exp=%h gap=8", ticks, en_a, gap, ~(6'd1 << cur));
        end
        ticks++;
        gap = 0;
        prev = en_a;
      end
    end
    checks++; if (ticks != 12) begin failures++; $display("FAIL scan_walk_count got=%0d exp=12", ticks); end
  endtask

  task automatic test_overflow_b;
    int unsigned bc;
    logic [63:0] segs;
    logic [23:0] exp_ovf = {8'hBF, 8'hBF, 8'hBF};
    logic [23:0] exp_999 = {8'h90, 8'h10, 8'h90};
    blank_b = 1'b1;
    convert(1'b1, 10'd1000, bc);
    checks++; if (bc != 11) begin failures++; $display("FAIL ovf_busy got=%0d exp=11", bc); end
    read_scan(1'b1, segs);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp_ovf[8*d +: 8]) begin
        failures++; $display("FAIL ovf1000 digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp_ovf[8*d +: 8]);
      end
    end
    convert(1'b1, 10'd999, bc);
    read_scan(1'b1, segs);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (segs[8*d +: 8] !== exp_999[8*d +: 8]) begin
        failures++; $display("FAIL b999 digit%0d got=%h exp=%h", d, segs[8*d +: 8], exp_999[8*d +: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_convert_237();
    test_convert_5();
    test_blank_boundary();
    test_ack_low();
    test_busy_ignore();
    test_reset_mid_shift();
    test_scan_walk();
    test_overflow_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
